// File: rtl/network_step_scheduler.sv
// network_step_scheduler: issues network requests per step and hands captured spike events downstream
module network_step_scheduler #(
  parameter int TEN_DATA_WIDTH  = 2,
  parameter int NEURON_ID_WIDTH = 9,
  parameter int STEP_WIDTH      = 20,
  parameter int TIMEOUT         = 15
) (
  input  logic                                      clk,
  input  logic                                      reset_l,
  input  logic                                      start,
  input  logic                                      abort,
  input  logic [STEP_WIDTH-1:0]                     num_steps,
  input  logic [3:0]                                cfg_bits_active,
  output logic [3:0]                                bits_in_active_neuron,
  output logic                                      en_network,
  input  logic                                      networkDone,
  input  logic [TEN_DATA_WIDTH+NEURON_ID_WIDTH-1:0] spike_out,
  output logic                                      evt_valid,
  input  logic                                      evt_ready,
  output logic [TEN_DATA_WIDTH+NEURON_ID_WIDTH-1:0] evt_data,
  output logic [STEP_WIDTH-1:0]                     step_count,
  output logic                                      busy,
  output logic                                      done,
  output logic                                      error
);
  localparam int DW = TEN_DATA_WIDTH + NEURON_ID_WIDTH;
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, SEND, DRAIN, FINISH} state_t;

  state_t          state_q, state_d;
  logic [STEP_WIDTH-1:0] steps_q, steps_d, count_q, count_d;
  logic [CW-1:0]   tmo_q, tmo_d;
  logic [3:0]      bits_q, bits_d;
  logic [DW-1:0]   data_q, data_d;
  logic            err_q, err_d, en_q, en_d, valid_q, valid_d, done_q, done_d, busy_q, busy_d;
  logic            tmo_hit;

  assign tmo_hit = (tmo_q + CW'(1)) == CW'(TIMEOUT);

  always_comb begin
    state_d = state_q;
    steps_d = steps_q;
    count_d = count_q;
    tmo_d   = tmo_q;
    bits_d  = bits_q;
    data_d  = data_q;
    err_d   = err_q;
    case (state_q)
      IDLE: if (start) begin
        steps_d = num_steps;
        count_d = '0;
        err_d   = 1'b0;
        bits_d  = cfg_bits_active < 4'd2 ? 4'd2 : cfg_bits_active > 4'd9 ? 4'd9 : cfg_bits_active;
        state_d = num_steps == '0 ? FINISH : ISSUE;
      end
      ISSUE: begin
        tmo_d   = '0;
        state_d = abort ? IDLE : WAIT;
      end
      WAIT: if (abort) begin
        tmo_d   = '0;
        state_d = DRAIN;
      end else if (networkDone) begin
        data_d  = spike_out;
        state_d = SEND;
      end else begin
        tmo_d   = tmo_q + CW'(1);
        err_d   = err_q | tmo_hit;
        state_d = tmo_hit ? IDLE : WAIT;
      end
      SEND: if (abort) begin
        state_d = IDLE;
      end else if (evt_ready) begin
        count_d = count_q + STEP_WIDTH'(1);
        state_d = count_d == steps_q ? FINISH : ISSUE;
      end
      DRAIN: begin
        tmo_d   = tmo_q + CW'(1);
        state_d = (networkDone || tmo_hit) ? IDLE : DRAIN;
      end
      default: state_d = IDLE;
    endcase
    en_d    = state_d == ISSUE;
    valid_d = state_d == SEND;
    done_d  = state_d == FINISH;
    busy_d  = state_d != IDLE;
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      state_q <= IDLE;
      steps_q <= '0;
      count_q <= '0;
      tmo_q   <= '0;
      bits_q  <= 4'd9;
      data_q  <= '0;
      err_q   <= 1'b0;
      en_q    <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      steps_q <= steps_d;
      count_q <= count_d;
      tmo_q   <= tmo_d;
      bits_q  <= bits_d;
      data_q  <= data_d;
      err_q   <= err_d;
      en_q    <= en_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign bits_in_active_neuron = bits_q;
  assign en_network            = en_q;
  assign evt_valid             = valid_q;
  assign evt_data              = data_q;
  assign step_count            = count_q;
  assign busy                  = busy_q;
  assign done                  = done_q;
  assign error                 = err_q;
endmodule

// File: tb/tb_network_step_scheduler.sv
// tb_network_step_scheduler: directed scenario tests with a fixed-latency network model
module tb_network_step_scheduler;
  logic        clk = 0, reset_l = 0, start = 0, abort = 0, networkDone = 0, evt_ready = 0;
  logic [19:0] num_steps = 0;
  logic [3:0]  cfg_bits_active = 0;
  logic [3:0]  bits_in_active_neuron;
  logic        en_network, evt_valid, busy, done, error;
  logic [10:0] spike_out = 0, evt_data, exp_data, held;
  logic [19:0] step_count;
  logic [3:0]  pipe = 0;
  logic        net_on = 1;
  int          resp_n = 0;
  int          total = 0, bad = 0;

  network_step_scheduler dut (
    .clk(clk), .reset_l(reset_l), .start(start), .abort(abort), .num_steps(num_steps),
    .cfg_bits_active(cfg_bits_active), .bits_in_active_neuron(bits_in_active_neuron),
    .en_network(en_network), .networkDone(networkDone), .spike_out(spike_out),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_data(evt_data),
    .step_count(step_count), .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  // network answers in the third cycle after the en_network cycle
  always @(posedge clk) begin
    #2;
    pipe = {pipe[2:0], en_network & net_on};
    networkDone = pipe[3];
    if (pipe[3]) begin
      resp_n++;
      spike_out = {resp_n[1:0], 9'(resp_n * 37 + 5)};
    end
  end

  task automatic do_start(input logic [19:0] ns, input logic [3:0] cfg);
    @(negedge clk);
    start = 1; num_steps = ns; cfg_bits_active = cfg;
    @(negedge clk);
    start = 0;
  endtask

  task automatic test_reset;
    total++; if ({en_network, evt_valid, busy, done, error} !== 5'b0) begin bad++; $display("FAIL reset_ctl got %b want 00000", {en_network, evt_valid, busy, done, error}); end
    total++; if (step_count !== 0 || evt_data !== 0) begin bad++; $display("FAIL reset_data got cnt=%0d data=%0h want 0 0", step_count, evt_data); end
    total++; if (bits_in_active_neuron !== 4'd9) begin bad++; $display("FAIL reset_bits got %0d want 9", bits_in_active_neuron); end
  endtask

  task automatic test_nominal;
    logic [19:0] ec;
    net_on = 1; evt_ready = 1;
    do_start(3, 9);
    for (int c = 1; c <= 17; c++) begin
      ec = c >= 16 ? 3 : c >= 11 ? 2 : c >= 6 ? 1 : 0;
      total++; if (en_network !== (c == 1 || c == 6 || c == 11)) begin bad++; $display("FAIL nom_en c%0d got %b", c, en_network); end
      total++; if (evt_valid !== (c == 5 || c == 10 || c == 15)) begin bad++; $display("FAIL nom_valid c%0d got %b", c, evt_valid); end
      total++; if (done !== (c == 16)) begin bad++; $display("FAIL nom_done c%0d got %b", c, done); end
      total++; if (busy !== (c <= 16)) begin bad++; $display("FAIL nom_busy c%0d got %b", c, busy); end
      total++; if (step_count !== ec) begin bad++; $display("FAIL nom_cnt c%0d got %0d want %0d", c, step_count, ec); end
      if (evt_valid) begin
        total++; if (evt_data !== exp_data) begin bad++; $display("FAIL nom_data c%0d got %0h want %0h", c, evt_data, exp_data); end
      end
      if (networkDone) exp_data = spike_out;
      @(negedge clk);
    end
    total++; if (error !== 0 || bits_in_active_neuron !== 4'd9) begin bad++; $display("FAIL nom_end got err=%b bits=%0d want 0 9", error, bits_in_active_neuron); end
  endtask

  task automatic test_clamp;
    logic [3:0] cfgs [3] = '{4'd0, 4'd12, 4'd5};
    logic [3:0] exps [3] = '{4'd2, 4'd9, 4'd5};
    for (int i = 0; i < 3; i++) begin
      do_start(0, cfgs[i]);
      total++; if (done !== 1 || en_network !== 0 || busy !== 1) begin bad++; $display("FAIL zero_c1 got done=%b en=%b busy=%b want 1 0 1", done, en_network, busy); end
      total++; if (bits_in_active_neuron !== exps[i]) begin bad++; $display("FAIL clamp cfg=%0d got %0d want %0d", cfgs[i], bits_in_active_neuron, exps[i]); end
      @(negedge clk);
      total++; if (done !== 0 || en_network !== 0 || busy !== 0) begin bad++; $display("FAIL zero_c2 got done=%b en=%b busy=%b want 0 0 0", done, en_network, busy); end
    end
  endtask

  task automatic test_backpressure;
    net_on = 1; evt_ready = 0;
    do_start(2, 4);
    repeat (4) @(negedge clk);
    total++; if (evt_valid !== 1) begin bad++; $display("FAIL bp_valid5 got %b want 1", evt_valid); end
    held = evt_data;
    for (int c = 5; c <= 14; c++) begin
      total++; if (evt_valid !== 1 || evt_data !== held || en_network !== 0 || step_count !== 0) begin
        bad++; $display("FAIL bp_hold c%0d got v=%b d=%0h en=%b cnt=%0d want 1 %0h 0 0", c, evt_valid, evt_data, en_network, step_count, held);
      end
      @(negedge clk);
    end
    evt_ready = 1;
    @(negedge clk);
    total++; if (en_network !== 1 || step_count !== 1 || evt_valid !== 0) begin bad++; $display("FAIL bp_release got en=%b cnt=%0d v=%b want 1 1 0", en_network, step_count, evt_valid); end
    for (int i = 0; i < 20 && !done; i++) @(negedge clk);
    total++; if (done !== 1 || step_count !== 2 || bits_in_active_neuron !== 4'd4) begin bad++; $display("FAIL bp_end got done=%b cnt=%0d bits=%0d want 1 2 4", done, step_count, bits_in_active_neuron); end
    @(negedge clk);
  endtask

  task automatic test_timeout;
    net_on = 0; evt_ready = 1;
    do_start(1, 9);
    for (int c = 1; c <= 17; c++) begin
      total++; if (done !== 0) begin bad++; $display("FAIL to_done c%0d got 1 want 0", c); end
      total++; if (busy !== (c <= 16) || error !== (c == 17)) begin bad++; $display("FAIL to_state c%0d got busy=%b err=%b", c, busy, error); end
      if (c < 17) @(negedge clk);
    end
    repeat (3) @(negedge clk);
    total++; if (error !== 1) begin bad++; $display("FAIL to_sticky got %b want 1", error); end
    net_on = 1;
    do_start(0, 9);
    total++; if (error !== 0) begin bad++; $display("FAIL to_clear got %b want 0", error); end
    @(negedge clk);
  endtask

  task automatic test_abort;
    net_on = 1; evt_ready = 1;
    do_start(2, 9);
    @(negedge clk);
    abort = 1;
    @(negedge clk);
    abort = 0;
    for (int c = 3; c <= 7; c++) begin
      total++; if (busy !== (c <= 4) || evt_valid !== 0 || done !== 0 || step_count !== 0) begin
        bad++; $display("FAIL ab_wait c%0d got busy=%b v=%b done=%b cnt=%0d", c, busy, evt_valid, done, step_count);
      end
      @(negedge clk);
    end
    do_start(2, 9);
    repeat (4) @(negedge clk);
    total++; if (evt_valid !== 1) begin bad++; $display("FAIL ab_send_v got %b want 1", evt_valid); end
    abort = 1;
    @(negedge clk);
    abort = 0;
    total++; if (busy !== 0 || evt_valid !== 0 || en_network !== 0 || step_count !== 0 || done !== 0) begin
      bad++; $display("FAIL ab_send got busy=%b v=%b en=%b cnt=%0d done=%b want all 0", busy, evt_valid, en_network, step_count, done);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_busy_reset;
    net_on = 1; evt_ready = 0;
    do_start(2, 9);
    @(negedge clk);
    start = 1; num_steps = 7; cfg_bits_active = 3;
    @(negedge clk);
    start = 0;
    repeat (2) @(negedge clk);
    total++; if (evt_valid !== 1 || bits_in_active_neuron !== 4'd9) begin bad++; $display("FAIL busy_start got v=%b bits=%0d want 1 9", evt_valid, bits_in_active_neuron); end
    evt_ready = 1;
    for (int i = 0; i < 20 && !done; i++) @(negedge clk);
    total++; if (done !== 1 || step_count !== 2) begin bad++; $display("FAIL busy_steps got done=%b cnt=%0d want 1 2", done, step_count); end
    @(negedge clk);
    evt_ready = 0;
    do_start(3, 6);
    repeat (5) @(negedge clk);
    #2 reset_l = 0;
    #1;
    total++; if ({en_network, evt_valid, busy, done, error} !== 5'b0 || step_count !== 0 || evt_data !== 0) begin
      bad++; $display("FAIL async_rst got ctl=%b cnt=%0d d=%0h want 0", {en_network, evt_valid, busy, done, error}, step_count, evt_data);
    end
    total++; if (bits_in_active_neuron !== 4'd9) begin bad++; $display("FAIL async_bits got %0d want 9", bits_in_active_neuron); end
    @(negedge clk);
    reset_l = 1;
    repeat (2) @(negedge clk);
    total++; if (busy !== 0 || done !== 0) begin bad++; $display("FAIL post_rst got busy=%b done=%b want 0 0", busy, done); end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    test_reset;
    reset_l = 1;
    @(negedge clk);
    test_nominal;
    test_clamp;
    test_backpressure;
    test_timeout;
    test_abort;
    test_busy_reset;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
